// File: rtl/cb_arb.sv
`default_nettype none
// ============================================================================
// Module   : cb_arb
// Brief    : N-port wormhole crossbar arbiter with per-input flit FIFOs and
//            per-output round-robin allocators that lock for a whole packet.
// Revision : 1.0 - initial release
// ============================================================================
module cb_arb #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [N*(DW+2)-1:0] idata,
    output logic [N-1:0]        ifull,
    output logic [N*(DW+2)-1:0] odata,
    input  logic [N-1:0]        oready,
    output logic [N-1:0]        ovf
);
    localparam int c_LW = $clog2(N);
    localparam int c_FW = DW + 2;
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [1:0] c_T_IDLE = 2'b00;
    localparam logic [1:0] c_T_HEAD = 2'b10;
    localparam logic [1:0] c_T_TAIL = 2'b11;

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    // Input FIFOs
    logic [c_FW-1:0] r_mem   [N][DEPTH];
    logic [c_AW-1:0] r_wptr  [N];
    logic [c_AW-1:0] r_rptr  [N];
    logic [c_CW-1:0] r_cnt   [N];
    logic [N-1:0]    r_full;
    logic [N-1:0]    r_ovf;

    // Output allocators
    logic [0:0]      r_state [N];
    logic [c_LW-1:0] r_owner [N];
    logic [c_LW-1:0] r_rr    [N];
    logic [c_FW-1:0] r_odata [N];

    logic [c_FW-1:0] w_in      [N];
    logic [c_FW-1:0] w_front   [N];
    logic [c_LW-1:0] w_dest    [N];
    logic [c_CW-1:0] w_cnt_nxt [N];
    logic [N-1:0]    w_empty;
    logic [N-1:0]    w_is_head;
    logic [N-1:0]    w_wr;
    logic [N-1:0]    w_drop;
    logic [N-1:0]    w_locked;
    logic [N-1:0]    w_xfer;
    logic [N-1:0]    w_discard;
    logic [N-1:0]    w_pop;
    logic [N-1:0]    w_gnt_vld;
    logic [c_LW-1:0] w_gnt_idx [N];
    logic [c_LW-1:0] w_try;

    for (genvar p = 0; p < N; p++) begin : g_port
        assign w_in[p]      = idata[p*c_FW +: c_FW];
        assign w_front[p]   = r_mem[p][r_rptr[p]];
        assign w_dest[p]    = w_front[p][c_LW-1:0];
        assign w_empty[p]   = (r_cnt[p] == '0);
        assign w_is_head[p] = ~w_empty[p] & (w_front[p][c_FW-1 -: 2] == c_T_HEAD);
        assign w_wr[p]      = (w_in[p][c_FW-1 -: 2] != c_T_IDLE) & ~r_full[p];
        assign w_drop[p]    = (w_in[p][c_FW-1 -: 2] != c_T_IDLE) &  r_full[p];
        assign w_cnt_nxt[p] = r_cnt[p] + c_CW'(w_wr[p]) - c_CW'(w_pop[p]);
        assign odata[p*c_FW +: c_FW] = r_odata[p];
    end

    assign ifull = r_full;
    assign ovf   = r_ovf;

    // An unlocked input whose front is not a head has lost its packet context.
    always_comb begin
        w_locked = '0;
        w_xfer   = '0;
        w_pop    = '0;
        for (int q = 0; q < N; q++) begin
            if (r_state[q] == c_ST_LOCKED) begin
                w_locked[r_owner[q]] = 1'b1;
                w_xfer[q]            = oready[q] & ~w_empty[r_owner[q]];
            end
        end
        w_discard = ~w_locked & ~w_empty & ~w_is_head;
        for (int q = 0; q < N; q++) begin
            if (w_xfer[q]) begin
                w_pop[r_owner[q]] = 1'b1;
            end
        end
        w_pop = w_pop | w_discard;
    end

    // Index arithmetic is c_LW bits wide, so the scan wraps modulo N for free.
    always_comb begin
        w_try = '0;
        for (int q = 0; q < N; q++) begin
            w_gnt_vld[q] = 1'b0;
            w_gnt_idx[q] = r_rr[q];
            for (int k = 0; k < N; k++) begin
                w_try = r_rr[q] + c_LW'(k);
                if (!w_gnt_vld[q] && !w_locked[w_try] && w_is_head[w_try] &&
                    (w_dest[w_try] == c_LW'(q))) begin
                    w_gnt_vld[q] = 1'b1;
                    w_gnt_idx[q] = w_try;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < N; p++) begin
            if (w_wr[p]) begin
                r_mem[p][r_wptr[p]] <= w_in[p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int p = 0; p < N; p++) begin
                r_wptr[p] <= '0;
                r_rptr[p] <= '0;
                r_cnt[p]  <= '0;
            end
            r_full <= '0;
            r_ovf  <= '0;
        end else begin
            for (int p = 0; p < N; p++) begin
                if (w_wr[p]) begin
                    r_wptr[p] <= r_wptr[p] + c_AW'(1);
                end
                if (w_pop[p]) begin
                    r_rptr[p] <= r_rptr[p] + c_AW'(1);
                end
                r_cnt[p]  <= w_cnt_nxt[p];
                r_full[p] <= (w_cnt_nxt[p] == c_CW'(DEPTH));
                if (w_drop[p] | w_discard[p]) begin
                    r_ovf[p] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int q = 0; q < N; q++) begin
                r_state[q] <= c_ST_IDLE;
                r_owner[q] <= '0;
                r_rr[q]    <= '0;
                r_odata[q] <= '0;
            end
        end else begin
            for (int q = 0; q < N; q++) begin
                r_odata[q] <= '0;
                case (r_state[q])
                    c_ST_IDLE: begin
                        if (w_gnt_vld[q]) begin
                            r_state[q] <= c_ST_LOCKED;
                            r_owner[q] <= w_gnt_idx[q];
                            r_rr[q]    <= w_gnt_idx[q] + c_LW'(1);
                        end
                    end
                    c_ST_LOCKED: begin
                        if (w_xfer[q]) begin
                            r_odata[q] <= w_front[r_owner[q]];
                            if (w_front[r_owner[q]][c_FW-1 -: 2] == c_T_TAIL) begin
                                r_state[q] <= c_ST_IDLE;
                            end
                        end
                    end
                    default: r_state[q] <= c_ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
